// File: rtl/serial_loader8.sv
// serial_loader8
//
// Assembles an LSB-first serial bit stream into 8-bit words. Both sides use a
// ready/valid handshake, so the loader can be backpressured from downstream
// and can stall the upstream bit source.
//
// Optional feature macro: SERIAL_LOADER8_PARITY_EN
//   When defined, each frame carries a ninth bit holding the even-parity bit.
//   The parity_err port then reports a mismatch for the word being held.
//
// Ports:
//   clk         system clock, rising-edge active
//   reset_n     asynchronous active-low reset
//   s_valid     serial bit present on s_data
//   s_data      serial data bit, LSB of the word first
//   s_ready     loader can accept a bit this cycle
//   m_data      assembled 8-bit word
//   m_valid     m_data holds a complete word
//   m_ready     downstream takes the word this cycle
//   parity_err  (parity build only) received parity mismatch for m_data

module serial_loader8 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_valid,
  input  logic       s_data,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready
`ifdef SERIAL_LOADER8_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  typedef enum logic [1:0] {
    ST_SHIFT  = 2'd0,
`ifdef SERIAL_LOADER8_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_HOLD   = 2'd1
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] m_data_reg, m_data_next;
  logic       shift_en;

`ifdef SERIAL_LOADER8_PARITY_EN
  logic       perr_reg, perr_next;
`endif

  // A data bit is taken only while collecting data bits; HOLD deasserts
  // s_ready, so no bit can slip in while a finished word is waiting.
  assign shift_en = (state_reg == ST_SHIFT) && s_valid;

  // Each bit position is written only when the counter points at it, so the
  // word builds in place rather than by shifting.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shift
      assign shift_next[gi] = (shift_en && (cnt_reg == 3'(gi))) ? s_data
                                                                : shift_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    m_data_next = m_data_reg;
`ifdef SERIAL_LOADER8_PARITY_EN
    perr_next   = perr_reg;
`endif
    case (state_reg)
      ST_SHIFT: begin
        if (s_valid) begin
          // 3-bit counter wraps 7 -> 0 naturally on the completing bit.
          cnt_next = cnt_reg + 3'd1;
          if (cnt_reg == 3'd7) begin
`ifdef SERIAL_LOADER8_PARITY_EN
            state_next  = ST_PARITY;
`else
            m_data_next = shift_next;
            state_next  = ST_HOLD;
`endif
          end
        end
      end
`ifdef SERIAL_LOADER8_PARITY_EN
      ST_PARITY: begin
        if (s_valid) begin
          m_data_next = shift_reg;
          // Even parity: the XOR over data plus parity bit must be zero.
          perr_next   = ^{shift_reg, s_data};
          state_next  = ST_HOLD;
        end
      end
`endif
      ST_HOLD: begin
        if (m_ready) begin
          state_next = ST_SHIFT;
          cnt_next   = 3'd0;
        end
      end
      default: begin
        state_next = ST_SHIFT;
        cnt_next   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_SHIFT;
      cnt_reg    <= 3'd0;
      shift_reg  <= 8'h00;
      m_data_reg <= 8'h00;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      shift_reg  <= shift_next;
      m_data_reg <= m_data_next;
    end
  end

`ifdef SERIAL_LOADER8_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr_reg <= 1'b0;
    end else begin
      perr_reg <= perr_next;
    end
  end

  assign parity_err = perr_reg;
`endif

  // Handshake outputs decode straight from the state register, keeping every
  // output free of combinational paths from the inputs.
  assign s_ready = (state_reg != ST_HOLD);
  assign m_valid = (state_reg == ST_HOLD);
  assign m_data  = m_data_reg;

endmodule

// File: doc/serial_loader8.md
# serial_loader8

Serial-to-parallel loader that assembles an LSB-first serial bit stream into 8-bit words. It is the stage directly upstream of the 8-bit register bank and drives that register's data input. A ready/valid handshake on both sides provides backpressure. An optional parity stage checks each received byte.

## Interface
Parameters:
- none; word width is fixed at 8 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- s_valid  input  1  serial bit present on s_data.
- s_data  input  1  serial data bit, LSB of the word first.
- s_ready  output  1  loader can accept a bit this cycle.
- m_data  output  8  assembled word; feeds the register's d input.
- m_valid  output  1  m_data holds a complete word.
- m_ready  input  1  downstream takes the word this cycle.
- parity_err  output  1  present only with SERIAL_LOADER8_PARITY_EN; received parity mismatch for the current word.

## Operation
- Clocking and reset: one clock (clk). Reset (reset_n) is asynchronous and active-low.
- Reset values, forced immediately while reset_n=0:
  - state=SHIFT, bit count=0, shift register=0x00.
  - m_data=0x00, m_valid=0, parity_err=0.
  - s_ready=1 (decoded from state). No bit is accepted while reset_n=0.
- A bit is accepted on a rising edge where s_valid=1 and s_ready=1.
- A word transfers on a rising edge where m_valid=1 and m_ready=1.
- State SHIFT:
  - s_ready=1, m_valid=0.
  - Each accepted bit is written to shift position cnt, then cnt increments (3-bit counter, 0..7).
  - An accepted bit with cnt=7 completes the word.
  - Without parity: the completed word loads m_data, cnt wraps to 0, and the state goes to HOLD.
  - With parity: the state goes to PARITY.
  - If s_valid=0, the cycle is idle: nothing changes, and gaps of any length are allowed.
- State PARITY (macro only):
  - s_ready=1.
  - The next accepted bit is the even-parity bit. Then m_data is loaded, parity_err = XOR of the 8 data bits and the parity bit, and the state goes to HOLD.
- State HOLD:
  - s_ready=0, m_valid=1.
  - m_data and parity_err are stable until the transfer.
  - On transfer, the state returns to SHIFT with cnt=0.
  - s_valid is ignored while in HOLD; upstream must hold its bit.
- Simultaneous events: a transfer in HOLD and s_valid=1 in the same cycle do not accept the bit, because s_ready=0. The bit is accepted on the following cycle.
- Reset mid-word: the partial word is discarded, and the next accepted bit becomes bit 0.
- m_data never changes while m_valid=1.

## Timing
- Latency: m_valid rises on the same edge that accepts the last bit. The output is valid in the next cycle (1 cycle after bit 7, or after the parity bit).
- All outputs are registered or decoded from the state register. There is no combinational path from s_* or m_ready to any output.
- Throughput with s_valid=1 and m_ready=1 tied high:
  - 9 cycles per word without parity (8 SHIFT + 1 HOLD).
  - 10 cycles per word with parity.
- Backpressure: HOLD persists for as many cycles as m_ready=0. There is no data loss and no overrun.

## Configuration
- SERIAL_LOADER8_PARITY_EN defined:
  - PARITY state and parity_err port exist.
  - Frame is 9 bits: 8 data bits plus an even-parity bit.
- SERIAL_LOADER8_PARITY_EN undefined:
  - No PARITY state and no parity_err port.
  - Frame is 8 bits.
  - Behaviour otherwise identical.

## Test plan
- Reset then single word:
  - Stimulus: assert reset_n=0 for 2 cycles. Check m_valid=0, m_data=0x00, s_ready=1. Release, then send bits 1,0,1,0,0,1,0,1 on consecutive cycles.
  - Response: m_valid=1 and m_data=0xA5 in the cycle after the 8th bit. With m_ready=1, m_valid=0 and s_ready=1 one cycle later.
- Backpressure:
  - Stimulus: word 0x3C with m_ready=0 for 5 cycles and s_valid=1 throughout.
  - Response: s_ready=0 and m_data=0x3C stable for all 5 cycles, and no bit is consumed. After m_ready=1, the next 8 bits form the next word.
- Gapped input:
  - Stimulus: word 0x81 with s_valid=0 inserted between every bit.
  - Response: m_data=0x81, and m_valid asserts only after the 8th accepted bit.
- Reset mid-word:
  - Stimulus: 3 bits 1,1,1, then reset_n=0 asynchronously mid-cycle, then release and send 0x0F.
  - Response: outputs reset immediately, and the next word is m_data=0x0F, not corrupted by the earlier bits.
- Streaming:
  - Stimulus: m_ready=1 and s_valid=1 continuously, sending 0x01, 0x02, 0x03.
  - Response: three words with m_valid pulses 9 cycles apart (10 cycles apart with parity).
- Parity (macro defined):
  - Stimulus: 0xA5 with parity bit 0, then 0xA5 with parity bit 1.
  - Response: parity_err=0 for the first word, and parity_err=1 with m_data=0xA5 for the second.
